// File: rtl/cpu_trace_buffer_pkg.sv
// Shared types for the commit-trace buffer: FSM states, entry layout, pack/unpack helpers.
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_t;

    localparam int unsigned BASE_ENTRY_W = 102;

    localparam int unsigned WDATA_LSB = 0;
    localparam int unsigned WDATA_W   = 32;
    localparam int unsigned WADDR_LSB = 32;
    localparam int unsigned WADDR_W   = 5;
    localparam int unsigned WE_LSB    = 37;
    localparam int unsigned INST_LSB  = 38;
    localparam int unsigned INST_W    = 32;
    localparam int unsigned PC_LSB    = 70;
    localparam int unsigned PC_W      = 32;

`ifdef TRACE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INST_W-1:0]  inst;
        logic               we;
        logic [WADDR_W-1:0] waddr;
        logic [WDATA_W-1:0] wdata;
    } trace_entry_t;

    function automatic logic [BASE_ENTRY_W-1:0] pack_entry(
        input logic [31:0] pc,
        input logic [31:0] inst,
        input logic        we,
        input logic [4:0]  waddr,
        input logic [31:0] wdata
    );
        logic [BASE_ENTRY_W-1:0] e;
        e = '0;
        e[PC_LSB +: PC_W]       = pc;
        e[INST_LSB +: INST_W]   = inst;
        e[WE_LSB]               = we;
        e[WADDR_LSB +: WADDR_W] = waddr;
        e[WDATA_LSB +: WDATA_W] = wdata;
        return e;
    endfunction

    function automatic trace_entry_t unpack_entry(input logic [BASE_ENTRY_W-1:0] e);
        trace_entry_t t;
        t.pc    = e[PC_LSB +: PC_W];
        t.inst  = e[INST_LSB +: INST_W];
        t.we    = e[WE_LSB];
        t.waddr = e[WADDR_LSB +: WADDR_W];
        t.wdata = e[WDATA_LSB +: WDATA_W];
        return t;
    endfunction

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// Commit snoop and readout stream bundle; master = core/consumer side, slave = trace buffer.
interface cpu_trace_buffer_if
    import cpu_trace_pkg::*;
#(
    parameter int unsigned TS_W = 16
);
    localparam int unsigned ENTRY_W = BASE_ENTRY_W + (TS_EN ? TS_W : 0);

    logic               commit_valid;
    logic [31:0]        commit_pc;
    logic [31:0]        commit_inst;
    logic               commit_rf_we;
    logic [4:0]         commit_rf_waddr;
    logic [31:0]        commit_rf_wdata;
    logic               rd_valid;
    logic               rd_ready;
    logic [ENTRY_W-1:0] rd_data;
    logic               rd_last;

    modport master (
        output commit_valid, commit_pc, commit_inst, commit_rf_we, commit_rf_waddr,
               commit_rf_wdata, rd_ready,
        input  rd_valid, rd_data, rd_last
    );

    modport slave (
        input  commit_valid, commit_pc, commit_inst, commit_rf_we, commit_rf_waddr,
               commit_rf_wdata, rd_ready,
        output rd_valid, rd_data, rd_last
    );

endinterface

// File: rtl/cpu_trace_buffer_trace_mem.sv
// Trace storage: flop array with one synchronous write port and one asynchronous read port.
module trace_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 102,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Commit-trace capture: arm, PC-match trigger, post-trigger window, oldest-first drain.
// Optional TRACE_TIMESTAMP_EN prepends a free-running cycle timestamp to each entry.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 8,
    parameter int unsigned TS_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arm,
    input  logic                   trig_en,
    input  logic [31:0]            trig_pc,
    cpu_trace_buffer_if.slave      trace,
    output logic [1:0]             state,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int unsigned PW      = $clog2(DEPTH);
    localparam int unsigned CW      = PW + 1;
    localparam int unsigned ENTRY_W = BASE_ENTRY_W + (TS_EN ? TS_W : 0);

    trace_state_t       state_q, state_d;
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count_q, post_cnt;
    logic               overflow_q;
    logic               rearm, wr_en, trigger, pop, full, post_last, rd_valid;
    logic [ENTRY_W-1:0] wr_data, rd_data;

    always_comb begin
        rearm     = arm && (state_q == ST_IDLE || state_q == ST_DONE);
        wr_en     = trace.commit_valid && (state_q == ST_ARMED || state_q == ST_POST);
        trigger   = (state_q == ST_ARMED) && trace.commit_valid
                    && (!trig_en || trace.commit_pc == trig_pc);
        full      = (count_q == CW'(DEPTH));
        post_last = (state_q == ST_POST) && wr_en && (post_cnt + CW'(1) == CW'(POST_TRIG));
        rd_valid  = (state_q == ST_DONE) && (count_q != '0);
        pop       = rd_valid && trace.rd_ready;
    end

    // Oldest entry is derived rather than stored: each pop decrements count, advancing it by one.
    assign rd_ptr = wr_ptr - count_q[PW-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (arm) state_d = ST_ARMED;
            ST_ARMED: if (trigger) state_d = (POST_TRIG == 0) ? ST_DONE : ST_POST;
            ST_POST:  if (post_last) state_d = ST_DONE;
            ST_DONE: begin
                if (arm) begin
                    state_d = ST_ARMED;
                end else if (pop && count_q == CW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr     <= '0;
            count_q    <= '0;
            post_cnt   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (rearm) begin
                wr_ptr     <= '0;
                count_q    <= '0;
                post_cnt   <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    if (full) begin
                        overflow_q <= 1'b1;
                    end else begin
                        count_q <= count_q + CW'(1);
                    end
                end
                if (wr_en && state_q == ST_POST) begin
                    post_cnt <= post_cnt + CW'(1);
                end
                if (pop) begin
                    count_q <= count_q - CW'(1);
                end
            end
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= '0;
        end else if (rearm) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    assign wr_data = {ts, pack_entry(trace.commit_pc, trace.commit_inst, trace.commit_rf_we,
                                     trace.commit_rf_waddr, trace.commit_rf_wdata)};
`else
    assign wr_data = pack_entry(trace.commit_pc, trace.commit_inst, trace.commit_rf_we,
                                trace.commit_rf_waddr, trace.commit_rf_wdata);
`endif

    trace_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign trace.rd_valid = rd_valid;
    assign trace.rd_data  = rd_data;
    assign trace.rd_last  = rd_valid && (count_q == CW'(1));
    assign state          = state_q;
    assign count          = count_q;
    assign overflow       = overflow_q;

endmodule
